// File: rtl/periph_bus_controller.sv
// Memory-mapped peripheral controller: keypad event FIFO, status, display data/control registers.
// Optional KEY_IRQ_EN adds a registered key_irq output driven from irq_enable, FIFO occupancy and overflow.
module periph_bus_controller #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 4,
  parameter int KEY_W          = 4,
  parameter int KEY_FIFO_DEPTH = 8,
  parameter int DISP_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  input  logic              writeEnable,
  input  logic              readEnable,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic [DISP_W-1:0] display_data,
  output logic              display_dot,
  output logic              display_blank
`ifdef KEY_IRQ_EN
  ,
  output logic              key_irq
`endif
);

  localparam int PTR_W = $clog2(KEY_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] A_KEY_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_KEY_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_DISP_DATA  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_DISP_CTRL  = ADDR_W'(5);

  // Read handshake: a read is accepted every cycle readEnable is high (no
  // backpressure); dout_valid pulses for exactly one cycle on the following
  // cycle and dout holds its last value whenever dout_valid is low.

  logic [KEY_W-1:0]  r_fifo [KEY_FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [DISP_W-1:0] r_disp_data;
  logic              r_disp_dot;
  logic              r_disp_blank;
  logic              r_irq_en;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_key;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_wr_status;
  logic              w_wr_disp;
  logic              w_wr_ctrl;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(KEY_FIFO_DEPTH));
  assign w_rd_key = readEnable && (address == A_KEY_DATA);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the key.
  assign w_pop     = w_rd_key && !w_empty;
  assign w_push    = key_valid && (!w_full || w_pop);
  assign w_ovf_set = key_valid && w_full && !w_pop;

  assign w_wr_status = writeEnable && (address == A_KEY_STATUS);
  assign w_wr_disp   = writeEnable && (address == A_DISP_DATA);
  assign w_wr_ctrl   = writeEnable && (address == A_DISP_CTRL);
  assign w_ovf_clr   = w_wr_status && din[2];

  // Read mux sees only pre-edge state, so a same-cycle write or push is not visible.
  always_comb begin
    w_rdata = '0;
    case (address)
      A_KEY_DATA: begin
        if (!w_empty) w_rdata[KEY_W-1:0] = r_fifo[r_rd_ptr];
      end
      A_KEY_STATUS: begin
        w_rdata[0]    = w_empty;
        w_rdata[1]    = w_full;
        w_rdata[2]    = r_overflow;
        w_rdata[15:8] = 8'(r_count);
      end
      A_DISP_DATA: begin
        w_rdata[DISP_W-1:0] = r_disp_data;
      end
      A_DISP_CTRL: begin
        w_rdata[2:0] = {r_irq_en, r_disp_blank, r_disp_dot};
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= key_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over the W1C clear.
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_data  <= '0;
      r_disp_dot   <= 1'b0;
      r_disp_blank <= 1'b1;
      r_irq_en     <= 1'b0;
    end else begin
      if (w_wr_disp) r_disp_data <= din[DISP_W-1:0];
      if (w_wr_ctrl) begin
        r_disp_dot   <= din[0];
        r_disp_blank <= din[1];
        r_irq_en     <= din[2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= readEnable;
      if (readEnable) r_dout <= w_rdata;
    end
  end

`ifdef KEY_IRQ_EN
  logic r_key_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_irq <= 1'b0;
    end else begin
      r_key_irq <= r_irq_en && (!w_empty || r_overflow);
    end
  end

  assign key_irq = r_key_irq;
`endif

  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign display_data  = r_disp_data;
  assign display_dot   = r_disp_dot;
  assign display_blank = r_disp_blank;

endmodule

// File: tb/tb_periph_bus_controller.sv
// Bench for periph_bus_controller: reference model of FIFO and registers feeding a read-data scoreboard.
module tb_periph_bus_controller;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int KEY_W  = 4;
  localparam int DEPTH  = 8;
  localparam int DISP_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] din;
  logic              writeEnable;
  logic              readEnable;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic [DISP_W-1:0] display_data;
  logic              display_dot;
  logic              display_blank;
`ifdef KEY_IRQ_EN
  logic              key_irq;
`endif

  periph_bus_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY_W(KEY_W),
    .KEY_FIFO_DEPTH(DEPTH), .DISP_W(DISP_W)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .din(din),
    .writeEnable(writeEnable), .readEnable(readEnable),
    .dout(dout), .dout_valid(dout_valid),
    .key_valid(key_valid), .key_code(key_code),
    .display_data(display_data), .display_dot(display_dot),
    .display_blank(display_blank)
`ifdef KEY_IRQ_EN
    , .key_irq(key_irq)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [KEY_W-1:0]  key_q[$];
  logic              m_ovf;
  logic [DISP_W-1:0] m_disp;
  logic [2:0]        m_ctrl;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_status();
    logic [DATA_W-1:0] s;
    s = '0;
    s[0]    = (key_q.size() == 0);
    s[1]    = (key_q.size() == DEPTH);
    s[2]    = m_ovf;
    s[15:8] = 8'(key_q.size());
    return s;
  endfunction

  task automatic model_reset();
    key_q.delete();
    m_ovf  = 1'b0;
    m_disp = '0;
    m_ctrl = 3'b010;
  endtask

  // scoreboard: every dout_valid pops one expected read
  always @(negedge clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) check_eq("unexpected_valid", 32'(dout_valid), 32'd0);
      else                   check_eq("rdata", dout, exp_q.pop_front());
    end
  end

  // One bus cycle: update model from pre-cycle state, drive, then check outputs.
  task automatic bus_cycle(input logic kv, input logic [KEY_W-1:0] code,
                           input logic re, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] exp;
    logic              set_ovf;
    logic              irq_pre;
    exp     = '0;
    irq_pre = m_ctrl[2] & ((key_q.size() != 0) | m_ovf);
    if (re) begin
      case (addr)
        4'd0: if (key_q.size() != 0) exp = 32'(key_q[0]);
        4'd1: exp = m_status();
        4'd4: exp = m_disp;
        4'd5: exp = 32'(m_ctrl);
        default: exp = '0;
      endcase
    end
    if (re && addr == 4'd0 && key_q.size() != 0) void'(key_q.pop_front());
    set_ovf = 1'b0;
    if (kv) begin
      if (key_q.size() < DEPTH) key_q.push_back(code);
      else                      set_ovf = 1'b1;
    end
    if (we) begin
      case (addr)
        4'd1: if (wdata[2]) m_ovf = 1'b0;
        4'd4: m_disp = wdata;
        4'd5: m_ctrl = wdata[2:0];
        default: ;
      endcase
    end
    if (set_ovf) m_ovf = 1'b1;
    key_valid   = kv;
    key_code    = code;
    readEnable  = re;
    writeEnable = we;
    address     = addr;
    din         = wdata;
    if (re) exp_q.push_back(exp);
    @(negedge clk);
    key_valid   = 1'b0;
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    check_eq("display_data", display_data, m_disp);
    check_eq("display_dot", 32'(display_dot), 32'(m_ctrl[0]));
    check_eq("display_blank", 32'(display_blank), 32'(m_ctrl[1]));
`ifdef KEY_IRQ_EN
    check_eq("key_irq", 32'(key_irq), 32'(irq_pre));
`endif
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus_cycle(1'b0, '0, 1'b1, 1'b0, a, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_cycle(1'b0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic key(input logic [KEY_W-1:0] c);
    bus_cycle(1'b1, c, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle();
    bus_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] amap [5];
    amap[0] = 4'd0; amap[1] = 4'd1; amap[2] = 4'd4; amap[3] = 4'd5; amap[4] = 4'd7;
    reset = 1'b1; address = '0; din = '0; writeEnable = 1'b0; readEnable = 1'b0;
    key_valid = 1'b0; key_code = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_dout", dout, 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
    check_eq("rst_display_data", display_data, 32'd0);
    check_eq("rst_display_dot", 32'(display_dot), 32'd0);
    check_eq("rst_display_blank", 32'(display_blank), 32'd1);
    reset = 1'b0;

    rd(4'd1); rd(4'd5); rd(4'd7); rd(4'd2);

    key(4'h3); key(4'h7); key(4'hA);
    repeat (4) rd(4'd0);
    rd(4'd1);

    for (int i = 0; i < 9; i++) key(4'($urandom_range(0, 15)));
    rd(4'd1);
    wr(4'd1, 32'h4);
    rd(4'd1);
    bus_cycle(1'b1, 4'hC, 1'b1, 1'b0, 4'd0, '0);
    rd(4'd1);
    repeat (8) rd(4'd0);
    rd(4'd1);

    for (int i = 0; i < 8; i++) key(4'(i + 2));
    bus_cycle(1'b1, 4'hF, 1'b0, 1'b1, 4'd1, 32'h4);
    rd(4'd1);
    wr(4'd1, 32'hFFFF_FFFB);
    rd(4'd1);
    repeat (8) rd(4'd0);

    bus_cycle(1'b1, 4'h5, 1'b1, 1'b0, 4'd0, '0);
    rd(4'd1);
    rd(4'd0);

    wr(4'd4, 32'hDEAD_BEEF);
    wr(4'd5, 32'h1);
    rd(4'd4);
    rd(4'd5);
    bus_cycle(1'b0, '0, 1'b1, 1'b1, 4'd4, 32'h1234_5678);
    rd(4'd4);
    wr(4'd0, 32'hFFFF_FFFF);
    rd(4'd1);

    wr(4'd5, 32'h4);
    key(4'h9);
    idle();
    rd(4'd0);
    idle();
    idle();

    for (int i = 0; i < 400; i++) begin
      raddr = amap[$urandom_range(0, 4)];
      bus_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                raddr, $urandom());
    end

    key(4'h1); key(4'h2); wr(4'd5, 32'h5);
    @(negedge clk);
    address = 4'd1; readEnable = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
    check_eq("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check_eq("midrst_display_blank", 32'(display_blank), 32'd1);
`ifdef KEY_IRQ_EN
    check_eq("midrst_key_irq", 32'(key_irq), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) idle();
    rd(4'd1);
    rd(4'd0);
    idle();
    idle();

    check_eq("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
